// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the {row,col} key map and column drive helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_STAR   = 4'hE;
    localparam logic [3:0] KEY_HASH   = 4'hF;
    localparam logic [3:0] COLS_RESET = 4'b1110;

    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1,     4'h2, 4'h3,     4'hA,
        4'h4,     4'h5, 4'h6,     4'hB,
        4'h7,     4'h8, 4'h9,     4'hC,
        KEY_STAR, 4'h0, KEY_HASH, 4'hD
    };

    // Lowest-index active-low row wins when several rows are pulled low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rs);
        logic [1:0] r;
        if (!rs[0]) begin
            r = 2'd0;
        end else if (!rs[1]) begin
            r = 2'd1;
        end else if (!rs[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/keypad_scanner_row_synchronizer.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
// Resets to all ones (no key pressed).
module row_synchronizer (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // Double-register the rows into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, key encode, dav strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTO_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
`ifdef KEYPAD_AUTO_REPEAT_EN
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 256
`else
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] dataIn,
    output logic       dav,
    output logic       keyHeld
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE     = DW'(1);

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] RPT_ONE  = RW'(1);
    logic [RW-1:0] rpt_cnt;
`endif

    logic [3:0]    rs;
    state_t        state;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] stable_cnt;

    row_synchronizer u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rows),
        .q     (rs)
    );

    // Scan/debounce/emit/release FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SCAN;
            col        <= 2'd0;
            row        <= 2'd0;
            settle_cnt <= '0;
            stable_cnt <= '0;
            cols       <= COLS_RESET;
            dataIn     <= 4'h0;
            dav        <= 1'b0;
            keyHeld    <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rpt_cnt    <= '0;
`endif
        end else begin
            dav <= 1'b0;
            case (state)
                SCAN: begin
                    // The sample point also covers the two synchronizer stages.
                    if (settle_cnt == SETTLE_LAST) begin
                        if (rs == 4'hF) begin
                            col        <= col + 2'd1;
                            cols       <= col_drive(col + 2'd1);
                            settle_cnt <= '0;
                        end else begin
                            row        <= lowest_low_row(rs);
                            stable_cnt <= '0;
                            state      <= DEBOUNCE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (!rs[row]) begin
                        if (stable_cnt == DEB_LAST) begin
                            state   <= EMIT;
                            dataIn  <= KEY_MAP[{row, col}];
                            dav     <= 1'b1;
                            keyHeld <= 1'b1;
                        end else begin
                            stable_cnt <= stable_cnt + DEB_ONE;
                        end
                    end else begin
                        state      <= SCAN;
                        settle_cnt <= '0;
                    end
                end
                EMIT: begin
                    state      <= RELEASE;
                    stable_cnt <= '0;
`ifdef KEYPAD_AUTO_REPEAT_EN
                    rpt_cnt    <= RPT_ONE;
`endif
                end
                RELEASE: begin
                    if (rs == 4'hF) begin
                        if (stable_cnt == DEB_LAST) begin
                            keyHeld    <= 1'b0;
                            state      <= SCAN;
                            col        <= 2'd0;
                            cols       <= COLS_RESET;
                            settle_cnt <= '0;
                        end else begin
                            stable_cnt <= stable_cnt + DEB_ONE;
                        end
                    end else begin
                        stable_cnt <= '0;
                    end
`ifdef KEYPAD_AUTO_REPEAT_EN
                    // Counter phase is aligned so repeats land on EMIT + k*REPEAT_CYCLES.
                    if (!rs[row]) begin
                        if (rpt_cnt == RPT_LAST) begin
                            dav     <= 1'b1;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_ONE;
                        end
                    end else begin
                        rpt_cnt <= '0;
                    end
`endif
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SETTLE=2, DEBOUNCE=4).
// The auto-repeat scenario runs only when KEYPAD_AUTO_REPEAT_EN is defined.
module tb_keypad_scanner;

    logic       clock;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] dataIn;
    logic       dav;
    logic       keyHeld;

    logic [15:0] keys;   // physical key state, index r*4+c
    int checks;
    int failures;
    int dav_seen;
    logic ok;

    keypad_scanner #(
        .SETTLE_CYCLES   (2),
`ifdef KEYPAD_AUTO_REPEAT_EN
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
`else
        .DEBOUNCE_CYCLES (4)
`endif
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rows    (rows),
        .cols    (cols),
        .dataIn  (dataIn),
        .dav     (dav),
        .keyHeld (keyHeld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Passive matrix: a pressed key shorts its row to its driven (low) column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            if (dav) dav_seen++;
        end
    endtask

    task automatic wait_dav(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clock);
            if (dav) begin
                dav_seen++;
                found = 1'b1;
            end
        end
    endtask

    task automatic wait_cols(input logic [3:0] val, input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clock);
            if (dav) dav_seen++;
            if (cols == val) found = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clock);
            if (dav) dav_seen++;
            if (!keyHeld) found = 1'b1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dav_seen = 0;
        keys     = 16'h0000;
        reset    = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_cols", {28'd0, cols}, 32'hE);
        check_eq("rst_dav", {31'd0, dav}, 32'd0);
        check_eq("rst_data", {28'd0, dataIn}, 32'h0);
        check_eq("rst_held", {31'd0, keyHeld}, 32'd0);
        reset = 1'b0;
        tick(2);
        check_eq("scan_col0", {28'd0, cols}, 32'hE);
        tick(1);
        check_eq("scan_col1", {28'd0, cols}, 32'hD);

        // Key '5' (r1,c1), clean press and release
        dav_seen = 0;
        keys[1*4+1] = 1'b1;
        wait_dav(40, ok);
        check_eq("k5_dav", {31'd0, ok}, 32'd1);
        check_eq("k5_data", {28'd0, dataIn}, 32'h5);
        check_eq("k5_cols", {28'd0, cols}, 32'hD);
        check_eq("k5_held", {31'd0, keyHeld}, 32'd1);
        tick(1);
        check_eq("k5_pulse", {31'd0, dav}, 32'd0);
        tick(6);
        check_eq("k5_once", dav_seen, 32'd1);
        keys = 16'h0000;
        tick(5);
        check_eq("k5_held_rel", {31'd0, keyHeld}, 32'd1);
        tick(1);
        check_eq("k5_idle", {31'd0, keyHeld}, 32'd0);
        check_eq("k5_cols_rel", {28'd0, cols}, 32'hE);
        check_eq("k5_data_hold", {28'd0, dataIn}, 32'h5);

        // Asynchronous reset mid-scan
        tick(5);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_cols", {28'd0, cols}, 32'hE);
        check_eq("mid_rst_data", {28'd0, dataIn}, 32'h0);
        check_eq("mid_rst_dav", {31'd0, dav}, 32'd0);
        check_eq("mid_rst_held", {31'd0, keyHeld}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick(2);
        check_eq("resume_col0", {28'd0, cols}, 32'hE);
        tick(1);
        check_eq("resume_col1", {28'd0, cols}, 32'hD);

        // Reset while '7' (r2,c0) held: re-detected once after reset
        dav_seen = 0;
        keys[2*4+0] = 1'b1;
        wait_dav(40, ok);
        check_eq("k7_dav", {31'd0, ok}, 32'd1);
        check_eq("k7_data", {28'd0, dataIn}, 32'h7);
        tick(2);
        reset = 1'b1;
        #1;
        check_eq("k7_rst_held", {31'd0, keyHeld}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        dav_seen = 0;
        wait_dav(40, ok);
        check_eq("k7_redav", {31'd0, ok}, 32'd1);
        check_eq("k7_redata", {28'd0, dataIn}, 32'h7);
        tick(6);
        check_eq("k7_reonce", dav_seen, 32'd1);
        keys = 16'h0000;
        wait_idle(20, ok);
        check_eq("k7_idle", {31'd0, ok}, 32'd1);

        // '#' (r3,c2) bouncing on its column, then stable
        wait_cols(4'b1011, 30, ok);
        check_eq("hash_col", {31'd0, ok}, 32'd1);
        dav_seen = 0;
        keys[3*4+2] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            keys[3*4+2] = (i % 2 == 0);
        end
        check_eq("hash_bounce", dav_seen, 32'd0);
        tick(4);
        check_eq("hash_settle", dav_seen, 32'd0);
        wait_dav(30, ok);
        check_eq("hash_dav", {31'd0, ok}, 32'd1);
        check_eq("hash_data", {28'd0, dataIn}, 32'hF);
        check_eq("hash_cols", {28'd0, cols}, 32'hB);
        tick(6);
        check_eq("hash_once", dav_seen, 32'd1);
        keys = 16'h0000;
        wait_idle(20, ok);
        check_eq("hash_idle", {31'd0, ok}, 32'd1);

        // '1' and '4' together, then 'A' pressed while held
        dav_seen = 0;
        keys[0*4+0] = 1'b1;
        keys[1*4+0] = 1'b1;
        wait_dav(40, ok);
        check_eq("k14_dav", {31'd0, ok}, 32'd1);
        check_eq("k14_data", {28'd0, dataIn}, 32'h1);
        check_eq("k14_cols", {28'd0, cols}, 32'hE);
        keys[0*4+3] = 1'b1;
        tick(8);
        check_eq("kA_ignored", dav_seen, 32'd1);
        check_eq("kA_data_hold", {28'd0, dataIn}, 32'h1);
        keys[0*4+0] = 1'b0;
        keys[1*4+0] = 1'b0;
        wait_dav(60, ok);
        check_eq("kA_dav", {31'd0, ok}, 32'd1);
        check_eq("kA_data", {28'd0, dataIn}, 32'hA);
        check_eq("kA_cols", {28'd0, cols}, 32'h7);
        check_eq("kA_count", dav_seen, 32'd2);
        keys = 16'h0000;
        wait_idle(20, ok);
        check_eq("kA_idle", {31'd0, ok}, 32'd1);

        // 'D' (r3,c3) pressed for only 3 cycles
        wait_cols(4'b0111, 30, ok);
        check_eq("kD_col", {31'd0, ok}, 32'd1);
        dav_seen = 0;
        keys[3*4+3] = 1'b1;
        tick(3);
        keys = 16'h0000;
        tick(4);
        check_eq("kD_cols", {28'd0, cols}, 32'h7);
        tick(10);
        check_eq("kD_nodav", dav_seen, 32'd0);
        check_eq("kD_held", {31'd0, keyHeld}, 32'd0);

`ifdef KEYPAD_AUTO_REPEAT_EN
        // Auto-repeat on '0' (r3,c1): strobes at EMIT+8, +16, +24
        dav_seen = 0;
        keys[3*4+1] = 1'b1;
        wait_dav(40, ok);
        check_eq("rpt_first", {31'd0, ok}, 32'd1);
        check_eq("rpt_data0", {28'd0, dataIn}, 32'h0);
        for (int k = 1; k <= 29; k++) begin
            tick(1);
            check_eq("rpt_dav", {31'd0, dav}, {31'd0, (k % 8 == 0)});
        end
        check_eq("rpt_count", dav_seen, 32'd4);
        check_eq("rpt_data", {28'd0, dataIn}, 32'h0);
        keys = 16'h0000;
        dav_seen = 0;
        tick(20);
        check_eq("rpt_after_rel", dav_seen, 32'd0);
        check_eq("rpt_idle", {31'd0, keyHeld}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream front end of the manual-control path.
- Scans a 4x4 matrix keypad, synchronizes and debounces the row lines, and encodes the pressed key as a 4-bit code.
- Issues a one-cycle dav strobe per accepted press; dav and dataIn feed the manual control unit directly.
- One press yields exactly one strobe; the key must be released before another is accepted.

Parameters:
- SETTLE_CYCLES, 4: cycles each column is driven before the rows are sampled (minimum 1).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press, and to accept a release (minimum 2).
- REPEAT_CYCLES, 256: auto-repeat period in cycles; used only with KEYPAD_AUTO_REPEAT_EN.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- rows  in  4  keypad row lines, active-low, asynchronous to clock.
- cols  out  4  column drive, active-low one-hot.
- dataIn  out  4  code of the last accepted key.
- dav  out  1  one-cycle strobe: dataIn holds a new key.
- keyHeld  out  1  high from acceptance of a press until its release is accepted.

Behaviour:
- Reset (async, active-high) values:
  - cols=4'b1110, dataIn=4'h0, dav=0, keyHeld=0.
  - State SCAN; all counters 0; synchronizer flops all 1.
- Row synchronization: two-flop synchronizer on rows. All decisions use the synchronized value rs.
- Key map, by row r (0-3) and column c (0-3):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *=E, 0, #=F, D
- FSM states: SCAN, DEBOUNCE, EMIT, RELEASE.
- SCAN:
  - Drive column c. The settle counter counts SETTLE_CYCLES cycles, then rs is sampled.
  - If rs==4'hF: advance to column (c+1) mod 4 (3 wraps to 0) and clear the settle counter.
  - Otherwise: latch c and the lowest-index low row r, then go to DEBOUNCE. The column freezes.
- DEBOUNCE:
  - Each cycle, check that rs[r] is still 0.
  - After DEBOUNCE_CYCLES consecutive good cycles, go to EMIT.
  - If rs[r] goes high at any point, return to SCAN on the same column with the settle counter cleared. No dav is issued.
- EMIT (exactly one cycle):
  - dataIn <= map(r,c) and dav=1 in this cycle.
  - keyHeld goes to 1; then go to RELEASE.
- RELEASE:
  - The column stays frozen.
  - After rs==4'hF for DEBOUNCE_CYCLES consecutive cycles: keyHeld=0, go to SCAN at column 0.
  - Any low row restarts the release count.
- dataIn holds its value between strobes. dav is registered; it is never high two consecutive cycles without auto-repeat.
- Latency from a clean press on the driven column to dav: 2 (sync) + remaining settle cycles + DEBOUNCE_CYCLES + 1.
- Simultaneous keys:
  - Same column: the lowest row wins.
  - A key in another column pressed while one is held is ignored until release is accepted and a fresh scan finds it.
- Reset mid-operation (any state): immediately return to reset values. A press still held after reset is re-detected and re-emitted once.
- Counter widths: $clog2(param)+1 bits. Counters saturate and never wrap.

Optional Feature:
- Macro KEYPAD_AUTO_REPEAT_EN.
- Defined:
  - In RELEASE, while rs[r] stays 0, a repeat counter counts REPEAT_CYCLES cycles.
  - At terminal count it re-strobes dav for one cycle with the same dataIn and restarts.
  - The first repeat occurs REPEAT_CYCLES after EMIT.
- Undefined: no repeat counter is built; one strobe per press.

Decomposition:
- Package keypad_pkg:
  - state enum (SCAN, DEBOUNCE, EMIT, RELEASE).
  - 16-entry key map constant indexed {r,c}.
  - KEY_STAR=4'hE and KEY_HASH=4'hF.
  - cols reset value 4'b1110.
- One sub-module, row_synchronizer: 4-bit, two-flop, reset to all 1.

Test Plan (SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4):
1. Reset pulse mid-scan -> cols=1110, dav=0, dataIn=0, keyHeld=0 asynchronously; scan resumes at column 0.
2. Hold key '5' (r1,c1) cleanly -> exactly one dav with dataIn=4'h5; cols frozen at 1101; keyHeld=1 until 4 idle cycles after release, then cols=1110.
3. '#' (r3,c2) bounces low-high-low at 1-cycle intervals for 6 cycles, then stays low -> no dav during bounce; a single dav with dataIn=4'hF after stable debounce.
4. Press '1' (r0,c0) and '4' (r1,c0) together -> dataIn=4'h1 only; pressing 'A' (r0,c3) while held -> ignored; 'A' emitted (4'hA) only after '1'/'4' release completes.
5. Press 'D' (r3,c3) for 3 cycles only -> no dav, keyHeld stays 0, scan continues on column 3.
6. With KEYPAD_AUTO_REPEAT_EN and REPEAT_CYCLES=8, hold '0' for 30 cycles after EMIT -> dav at EMIT, then at +8, +16, and +24 cycles, each with dataIn=4'h0; none after release.
